// File: rtl/apb_frame_sequencer_if.sv
// APB bus bundle between the frame sequencer (master)
// and the frame controller register file (slave).
interface apb_frame_sequencer_if #(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 16
);
    logic [ADDRESSWIDTH-1:0] PADDR_o;
    logic [DATAWIDTH-1:0]    PWDATA_o;
    logic                    PWRITE_o;
    logic                    PSEL_o;
    logic                    PENABLE_o;
    logic [DATAWIDTH-1:0]    PRDATA_i;
    logic                    PREADY_i;

    modport master (
        output PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o,
        input  PRDATA_i, PREADY_i
    );

    modport slave (
        input  PADDR_o, PWDATA_o, PWRITE_o, PSEL_o, PENABLE_o,
        output PRDATA_i, PREADY_i
    );
endinterface

// File: rtl/apb_frame_sequencer.sv
// APB master running one lift-bus frame exchange:
// TX space check, frame write, RX wait, frame read back.
module apb_frame_sequencer #(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 16,
    parameter int POLL_MAX     = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_tx_i,
    input  logic [7:0]  cmd_i,
    input  logic [7:0]  id_i,
    input  logic [15:0] data_i,
    input  logic [11:0] frame_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_cmd_o,
    output logic [7:0]  rx_id_o,
    output logic [15:0] rx_data_o,
    output logic [11:0] rx_frame_o,
    apb_frame_sequencer_if.master apb
);

    typedef enum logic [3:0] {
        S_IDLE, S_POLL_TX, S_WR_CMD, S_WR_ID, S_WR_DATA, S_WR_TX,
        S_POLL_RX, S_RD_ID, S_RD_DATA, S_RD_CMD, S_RD_FRAME, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP, P_ACCESS, P_CAPTURE
    } phase_t;

    localparam logic [7:0] LP_POLL_LAST = 8'(POLL_MAX - 1);

    localparam logic [ADDRESSWIDTH-1:0] A_CMD    = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] A_TX     = ADDRESSWIDTH'(2);
    localparam logic [ADDRESSWIDTH-1:0] A_ID     = ADDRESSWIDTH'(3);
    localparam logic [ADDRESSWIDTH-1:0] A_DATA   = ADDRESSWIDTH'(4);
    localparam logic [ADDRESSWIDTH-1:0] A_RXFRM  = ADDRESSWIDTH'(5);
    localparam logic [ADDRESSWIDTH-1:0] A_RXID   = ADDRESSWIDTH'(6);
    localparam logic [ADDRESSWIDTH-1:0] A_RXDATA = ADDRESSWIDTH'(7);
    localparam logic [ADDRESSWIDTH-1:0] A_STAT   = ADDRESSWIDTH'(8);
    localparam logic [ADDRESSWIDTH-1:0] A_RXCMD  = ADDRESSWIDTH'(9);

    state_t r_state;
    state_t w_state_nxt;
    phase_t r_phase;
    phase_t w_phase_nxt;

    logic                    w_step;
    logic                    w_is_read;
    logic                    w_is_write;
    logic [ADDRESSWIDTH-1:0] w_addr;
    logic [DATAWIDTH-1:0]    w_wdata;

    logic [7:0]  r_cnt;
    logic        r_err;
    logic [7:0]  r_cmd;
    logic [7:0]  r_id;
    logic [15:0] r_data;
    logic [11:0] r_frame;
    logic [7:0]  r_rx_cmd;
    logic [7:0]  r_rx_id;
    logic [15:0] r_rx_data;
    logic [11:0] r_rx_frame;

    // State and bus phase registers; reset drops PSEL at once
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_phase <= P_SETUP;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next state: a step is write ACCESS done or read CAPTURE done
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_step      = 1'b0;
        if (r_state == S_IDLE) begin
            w_phase_nxt = P_SETUP;
            if (req_tx_i) begin
                w_state_nxt = S_POLL_TX;
            end
        end else if (r_state == S_DONE) begin
            w_phase_nxt = P_SETUP;
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_phase)
                P_SETUP: w_phase_nxt = P_ACCESS;
                P_ACCESS: begin
                    if (apb.PREADY_i) begin
                        if (w_is_read) begin
                            w_phase_nxt = P_CAPTURE;
                        end else begin
                            w_step = 1'b1;
                        end
                    end
                end
                P_CAPTURE: w_step = 1'b1;
                default: w_phase_nxt = P_SETUP;
            endcase
            if (w_step) begin
                w_phase_nxt = P_SETUP;
                unique case (r_state)
                    S_POLL_TX: begin
                        if (!apb.PRDATA_i[7]) begin
                            w_state_nxt = S_WR_CMD;
                        end else if (r_cnt == LP_POLL_LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                    S_WR_CMD:  w_state_nxt = S_WR_ID;
                    S_WR_ID:   w_state_nxt = S_WR_DATA;
                    S_WR_DATA: w_state_nxt = S_WR_TX;
                    S_WR_TX:   w_state_nxt = S_POLL_RX;
                    S_POLL_RX: begin
                        if (!apb.PRDATA_i[4]) begin
                            w_state_nxt = S_RD_ID;
                        end else if (r_cnt == LP_POLL_LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                    S_RD_ID:    w_state_nxt = S_RD_DATA;
                    S_RD_DATA:  w_state_nxt = S_RD_CMD;
                    S_RD_CMD:   w_state_nxt = S_RD_FRAME;
                    S_RD_FRAME: w_state_nxt = S_DONE;
                    default:    w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Datapath: request latch, poll counter, error flag, RX capture
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_cmd      <= '0;
            r_id       <= '0;
            r_data     <= '0;
            r_frame    <= '0;
            r_rx_cmd   <= '0;
            r_rx_id    <= '0;
            r_rx_data  <= '0;
            r_rx_frame <= '0;
        end else begin
            if (r_state == S_IDLE && req_tx_i) begin
                r_cmd   <= cmd_i;
                r_id    <= id_i;
                r_data  <= data_i;
                r_frame <= frame_i;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (w_step) begin
                unique case (r_state)
                    S_POLL_TX: begin
                        if (apb.PRDATA_i[7]) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == LP_POLL_LAST) r_err <= 1'b1;
                        end
                    end
                    S_POLL_RX: begin
                        if (apb.PRDATA_i[4]) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == LP_POLL_LAST) r_err <= 1'b1;
                        end
                    end
                    S_WR_TX:    r_cnt      <= '0;
                    S_RD_ID:    r_rx_id    <= apb.PRDATA_i[7:0];
                    S_RD_DATA:  r_rx_data  <= apb.PRDATA_i[15:0];
                    S_RD_CMD:   r_rx_cmd   <= apb.PRDATA_i[7:0];
                    S_RD_FRAME: r_rx_frame <= apb.PRDATA_i[11:0];
                    default: ;
                endcase
            end
        end
    end

    // Outputs: bus drive decoded from state, status flags
    always_comb begin
        w_is_read  = 1'b0;
        w_is_write = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        unique case (r_state)
            S_POLL_TX, S_POLL_RX: begin
                w_is_read = 1'b1;
                w_addr    = A_STAT;
            end
            S_WR_CMD: begin
                w_is_write = 1'b1;
                w_addr     = A_CMD;
                w_wdata    = DATAWIDTH'(r_cmd);
            end
            S_WR_ID: begin
                w_is_write = 1'b1;
                w_addr     = A_ID;
                w_wdata    = DATAWIDTH'(r_id);
            end
            S_WR_DATA: begin
                w_is_write = 1'b1;
                w_addr     = A_DATA;
                w_wdata    = DATAWIDTH'(r_data);
            end
            S_WR_TX: begin
                w_is_write = 1'b1;
                w_addr     = A_TX;
                w_wdata    = DATAWIDTH'(r_frame);
            end
            S_RD_ID: begin
                w_is_read = 1'b1;
                w_addr    = A_RXID;
            end
            S_RD_DATA: begin
                w_is_read = 1'b1;
                w_addr    = A_RXDATA;
            end
            S_RD_CMD: begin
                w_is_read = 1'b1;
                w_addr    = A_RXCMD;
            end
            S_RD_FRAME: begin
                w_is_read = 1'b1;
                w_addr    = A_RXFRM;
            end
            default: ;
        endcase
        apb.PSEL_o    = (w_is_read | w_is_write) && (r_phase != P_CAPTURE);
        apb.PENABLE_o = apb.PSEL_o && (r_phase == P_ACCESS);
        apb.PWRITE_o  = w_is_write;
        apb.PADDR_o   = w_addr;
        apb.PWDATA_o  = w_wdata;
        busy_o        = (r_state != S_IDLE);
        done_o        = (r_state == S_DONE);
        err_o         = done_o & r_err;
        rx_valid_o    = done_o & ~r_err;
    end

    assign rx_cmd_o   = r_rx_cmd;
    assign rx_id_o    = r_rx_id;
    assign rx_data_o  = r_rx_data;
    assign rx_frame_o = r_rx_frame;

endmodule

// File: tb/tb_apb_frame_sequencer.sv
// Bench for apb_frame_sequencer: APB slave model plus
// transaction-level reference of one frame exchange.
module tb_apb_frame_sequencer;

    localparam int PM = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  a;
        logic [15:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  cmd = '0;
    logic [7:0]  id = '0;
    logic [15:0] dat = '0;
    logic [11:0] frm = '0;
    logic        busy, done, err, rxv;
    logic [7:0]  rxc, rxi;
    logic [15:0] rxd;
    logic [11:0] rxf;

    apb_frame_sequencer_if #(.ADDRESSWIDTH(4), .DATAWIDTH(16)) bus ();

    apb_frame_sequencer #(
        .ADDRESSWIDTH(4), .DATAWIDTH(16), .POLL_MAX(PM)
    ) dut (
        .PCLK(clk), .PRESETn(rst_n), .req_tx_i(req),
        .cmd_i(cmd), .id_i(id), .data_i(dat), .frame_i(frm),
        .busy_o(busy), .done_o(done), .err_o(err),
        .rx_valid_o(rxv), .rx_cmd_o(rxc), .rx_id_o(rxi),
        .rx_data_o(rxd), .rx_frame_o(rxf), .apb(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [15:0] st[$];
    logic [15:0] rv_id, rv_data, rv_cmd, rv_frame;
    logic [3:0]  ws_addr = '0;
    int          ws_n = 0;
    int          wait_left = 0;
    int          st_rd = 0;
    int          s0 = 0;
    int          proto_err = 0;
    int          done_cnt = 0;
    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [3:0]  s_addr;
    logic [15:0] s_data;
    logic        s_wr;
    logic [15:0] rd;

    logic        exp_err;
    int          exp_lat;
    int          last_lat;
    logic [7:0]  m_cmd = '0;
    logic [7:0]  m_id = '0;
    logic [15:0] m_data = '0;
    logic [11:0] m_frame = '0;

    assign bus.PREADY_i = !(bus.PSEL_o && bus.PENABLE_o && wait_left != 0);

    // Slave register file model and transaction monitor
    always @(posedge clk) begin
        if (bus.PSEL_o && !bus.PENABLE_o) begin
            wait_left <= (bus.PADDR_o == ws_addr) ? ws_n : 0;
            s_addr <= bus.PADDR_o;
            s_data <= bus.PWDATA_o;
            s_wr   <= bus.PWRITE_o;
        end else if (bus.PSEL_o && bus.PENABLE_o) begin
            if (bus.PADDR_o !== s_addr || bus.PWDATA_o !== s_data ||
                bus.PWRITE_o !== s_wr)
                proto_err++;
            if (wait_left != 0) begin
                wait_left <= wait_left - 1;
            end else if (bus.PWRITE_o) begin
                obs_q.push_back({1'b1, bus.PADDR_o, bus.PWDATA_o});
            end else begin
                case (bus.PADDR_o)
                    4'd8: begin
                        rd = (st_rd - s0 < st.size()) ? st[st_rd - s0] : 16'h0;
                        st_rd++;
                    end
                    4'd6: rd = rv_id;
                    4'd7: rd = rv_data;
                    4'd9: rd = rv_cmd;
                    4'd5: rd = rv_frame;
                    default: rd = 16'hDEAD;
                endcase
                bus.PRDATA_i <= rd;
                obs_q.push_back({1'b0, bus.PADDR_o, rd});
            end
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    // Expected bus transactions, outcome and latency of one exchange
    task automatic model(input logic [7:0] c, input logic [7:0] i,
                         input logic [15:0] d, input logic [11:0] f);
        int idx = 0;
        int n = 0;
        logic [15:0] s;
        exp_q.delete();
        exp_err = 1'b0;
        while (1) begin
            s = (idx < st.size()) ? st[idx] : 16'h0;
            idx++; n++;
            exp_q.push_back({1'b0, 4'd8, s});
            if (!s[7]) break;
            if (n == PM) begin exp_err = 1'b1; break; end
        end
        if (!exp_err) begin
            exp_q.push_back({1'b1, 4'd1, 8'h00, c});
            exp_q.push_back({1'b1, 4'd3, 8'h00, i});
            exp_q.push_back({1'b1, 4'd4, d});
            exp_q.push_back({1'b1, 4'd2, 4'h0, f});
            n = 0;
            while (1) begin
                s = (idx < st.size()) ? st[idx] : 16'h0;
                idx++; n++;
                exp_q.push_back({1'b0, 4'd8, s});
                if (!s[4]) break;
                if (n == PM) begin exp_err = 1'b1; break; end
            end
        end
        if (!exp_err) begin
            exp_q.push_back({1'b0, 4'd6, rv_id});
            exp_q.push_back({1'b0, 4'd7, rv_data});
            exp_q.push_back({1'b0, 4'd9, rv_cmd});
            exp_q.push_back({1'b0, 4'd5, rv_frame});
            m_id    = rv_id[7:0];
            m_data  = rv_data;
            m_cmd   = rv_cmd[7:0];
            m_frame = rv_frame[11:0];
        end
        exp_lat = 1;
        foreach (exp_q[k])
            exp_lat += (exp_q[k].wr ? 2 : 3) +
                       ((exp_q[k].a == ws_addr) ? ws_n : 0);
    endtask

    task automatic run(input logic [7:0] c, input logic [7:0] i,
                       input logic [15:0] d, input logic [11:0] f,
                       input bit pulse);
        int o0, d0, p0, n;
        bit got;
        model(c, i, d, f);
        @(negedge clk);
        o0 = obs_q.size(); d0 = done_cnt; p0 = proto_err; s0 = st_rd;
        cmd = c; id = i; dat = d; frm = f; req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req = 1'b0;
                cmd = ~c; id = ~i; dat = ~d; frm = ~f;
                check("busy_start", 32'(busy), 32'd1);
            end
            if (pulse && n == 10) req = 1'b1;
            if (pulse && n == 11) req = 1'b0;
            if (done) got = 1'b1;
        end
        last_lat = n;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("err", 32'(err), 32'(exp_err));
        check("rx_valid", 32'(rxv), 32'(!exp_err));
        check("busy_done", 32'(busy), 32'd1);
        check("rx_cmd", 32'(rxc), 32'(m_cmd));
        check("rx_id", 32'(rxi), 32'(m_id));
        check("rx_data", 32'(rxd), 32'(m_data));
        check("rx_frame", 32'(rxf), 32'(m_frame));
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("protocol", 32'(proto_err - p0), 32'd0);
        check("txn_count", 32'(obs_q.size() - o0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && o0 + k < obs_q.size(); k++)
            check($sformatf("txn%0d", k), 32'(obs_q[o0 + k]), 32'(exp_q[k]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bus"}, 32'({bus.PSEL_o, bus.PENABLE_o, bus.PWRITE_o,
                                  bus.PADDR_o, bus.PWDATA_o}), 32'd0);
        check({tag, "_flags"}, 32'({busy, done, err, rxv}), 32'd0);
        check({tag, "_rx"}, 32'({rxc, rxi, rxd}), 32'd0);
        check({tag, "_rxf"}, 32'(rxf), 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] v;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        rv_id = 16'h0011; rv_data = 16'h5678;
        rv_cmd = 16'h0022; rv_frame = 16'h0ABC;
        st = '{16'h0000, 16'h0000};
        run(8'hA5, 8'h3C, 16'h1234, 12'h0F0, 1'b0);
        check("nominal_lat", 32'(last_lat), 32'd27);

        rv_id = 16'hFF33; rv_data = 16'h9ABC;
        rv_cmd = 16'h1244; rv_frame = 16'hF555;
        st = '{16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0000};
        run(8'h01, 8'h02, 16'hBEEF, 12'h123, 1'b0);

        rv_id = 16'h00EE; rv_data = 16'h0000;
        rv_cmd = 16'h00DD; rv_frame = 16'h0FFF;
        st = '{16'h0000, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        run(8'h77, 8'h88, 16'h4321, 12'hFED, 1'b0);

        ws_addr = 4'd4; ws_n = 2;
        st = '{16'h0000, 16'h0000};
        run(8'hA5, 8'h3C, 16'h1234, 12'h0F0, 1'b0);
        check("wait_lat", 32'(last_lat), 32'd29);
        ws_addr = 4'd0; ws_n = 0;

        st = '{16'h0000, 16'h0000};
        @(negedge clk);
        cmd = 8'h5A; id = 8'hC3; dat = 16'h0F0F; frm = 12'hAAA;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!(bus.PSEL_o && bus.PENABLE_o && bus.PADDR_o == 4'd3) &&
               n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_wr_id", 32'(bus.PADDR_o == 4'd3 && bus.PENABLE_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midreset");
        m_cmd = '0; m_id = '0; m_data = '0; m_frame = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rv_id = 16'h0042; rv_data = 16'h1357;
        rv_cmd = 16'h0024; rv_frame = 16'h0246;
        st = '{16'h0000, 16'h0000};
        run(8'h10, 8'h20, 16'h3040, 12'h506, 1'b0);

        st = '{16'h0000, 16'h0010, 16'h0000};
        run(8'h99, 8'h66, 16'hCAFE, 12'h321, 1'b1);

        for (int k = 0; k < 25; k++) begin
            st.delete();
            for (int j = 0; j < 9; j++) begin
                v = 16'($urandom);
                v[7] = ($urandom_range(0, 2) == 0);
                v[4] = ($urandom_range(0, 2) == 0);
                st.push_back(v);
            end
            rv_id = 16'($urandom); rv_data = 16'($urandom);
            rv_cmd = 16'($urandom); rv_frame = 16'($urandom);
            ws_addr = 4'($urandom_range(1, 9));
            ws_n = $urandom_range(0, 3);
            run(8'($urandom), 8'($urandom), 16'($urandom),
                12'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
